// File: rtl/word_byte_serializer_pkg.sv
// Shared types and constants for the word-to-byte serializer.
package word_byte_serializer_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;
  localparam int unsigned CNT_W  = 2;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_SEND = 1'b1
  } state_t;

  // Lane 0 is the most significant byte of the word.
  localparam logic [CNT_W-1:0] LANE_B3 = 2'd0;
  localparam logic [CNT_W-1:0] LANE_B2 = 2'd1;
  localparam logic [CNT_W-1:0] LANE_B1 = 2'd2;
  localparam logic [CNT_W-1:0] LANE_B0 = 2'd3;

  localparam logic [CNT_W-1:0] LEN_MAX = 2'd3;

  typedef struct packed {
    logic [WORD_W-1:0] data;
    logic [CNT_W-1:0]  len;
  } word_beat_t;

  // Map the position within the byte stream onto a physical byte lane.
  function automatic logic [CNT_W-1:0] lane_of(input logic [CNT_W-1:0] idx,
                                               input bit msb_first);
    return msb_first ? idx : CNT_W'(LANE_B0 - idx);
  endfunction

endpackage

// File: rtl/word_byte_serializer_byte_lane_select.sv
// Combinational byte-lane extractor: lane 0 is bits [31:24].
module byte_lane_select
  import word_byte_serializer_pkg::*;
(
  input  logic [WORD_W-1:0] word,
  input  logic [CNT_W-1:0]  lane,
  output logic [BYTE_W-1:0] lane_byte
);

  always_comb begin
    lane_byte = '0;
    unique case (lane)
      LANE_B3: lane_byte = word[31:24];
      LANE_B2: lane_byte = word[23:16];
      LANE_B1: lane_byte = word[15:8];
      LANE_B0: lane_byte = word[7:0];
      default: lane_byte = '0;
    endcase
  end

endmodule

// File: rtl/word_byte_serializer.sv
// Serializes a 32-bit word into a valid/ready byte stream with zero-bubble
// back-to-back word acceptance on the last byte.
module word_byte_serializer
  import word_byte_serializer_pkg::*;
#(
  parameter bit MSB_FIRST = 1'b1,
  parameter bit FIXED_LEN = 1'b0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [WORD_W-1:0] in_data,
  input  logic [CNT_W-1:0]  in_nbytes,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_last,
  output logic              busy
);

  state_t            state, state_n;
  word_beat_t        held, held_n;
  logic [CNT_W-1:0]  idx, idx_n;
  logic              out_valid_n, out_last_n;
  logic [BYTE_W-1:0] out_data_n;

  logic              beat, accept;
  logic [WORD_W-1:0] sel_word;
  logic [CNT_W-1:0]  sel_idx, sel_len;
  logic [BYTE_W-1:0] lane_byte;

  assign beat     = out_valid && out_ready;
  assign in_ready = (state == ST_IDLE) || (beat && out_last);
  assign accept   = in_valid && in_ready;
  assign busy     = (state == ST_SEND);

  // Source of the byte loaded next: a fresh word on accept, else the held word.
  always_comb begin
    sel_word = held.data;
    sel_idx  = CNT_W'(idx + 1'b1);
    sel_len  = held.len;
    if (accept) begin
      sel_word = in_data;
      sel_idx  = '0;
      sel_len  = FIXED_LEN ? LEN_MAX : in_nbytes;
    end
  end

  byte_lane_select u_lane_select (
    .word      (sel_word),
    .lane      (lane_of(sel_idx, MSB_FIRST)),
    .lane_byte (lane_byte)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= ST_IDLE;
      held      <= '0;
      idx       <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_last  <= 1'b0;
    end else begin
      state     <= state_n;
      held      <= held_n;
      idx       <= idx_n;
      out_valid <= out_valid_n;
      out_data  <= out_data_n;
      out_last  <= out_last_n;
    end
  end

  // Accept has priority: it also covers the last-beat-plus-new-word case.
  always_comb begin
    state_n     = state;
    held_n      = held;
    idx_n       = idx;
    out_valid_n = out_valid;
    out_data_n  = out_data;
    out_last_n  = out_last;
    if (accept) begin
      state_n     = ST_SEND;
      held_n      = '{data: in_data, len: sel_len};
      idx_n       = '0;
      out_valid_n = 1'b1;
      out_data_n  = lane_byte;
      out_last_n  = (sel_idx == sel_len);
    end else if (beat && out_last) begin
      state_n     = ST_IDLE;
      idx_n       = '0;
      out_valid_n = 1'b0;
      out_data_n  = '0;
      out_last_n  = 1'b0;
    end else if (beat) begin
      idx_n      = sel_idx;
      out_data_n = lane_byte;
      out_last_n = (sel_idx == held.len);
    end
  end

endmodule

// File: tb/tb_word_byte_serializer.sv
// Bench for word_byte_serializer: three instances (MSB-first, LSB-first,
// fixed-length) driven by directed scenarios and a randomized stream.
module tb_word_byte_serializer;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        in_valid  [3];
  logic        out_ready [3];
  logic [31:0] in_data   [3];
  logic [1:0]  in_nbytes [3];
  logic        in_ready  [3];
  logic        out_valid [3];
  logic        out_last  [3];
  logic        busy      [3];
  logic [7:0]  out_data  [3];

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  // Instance 0: MSB first, 1: LSB first, 2: MSB first with fixed length.
  for (genvar g = 0; g < 3; g++) begin : g_dut
    word_byte_serializer #(
      .MSB_FIRST (1'(g != 1)),
      .FIXED_LEN (1'(g == 2))
    ) dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .in_valid  (in_valid[g]),
      .in_ready  (in_ready[g]),
      .in_data   (in_data[g]),
      .in_nbytes (in_nbytes[g]),
      .out_valid (out_valid[g]),
      .out_ready (out_ready[g]),
      .out_data  (out_data[g]),
      .out_last  (out_last[g]),
      .busy      (busy[g])
    );
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_word(input int d, input logic [31:0] w, input logic [1:0] nb);
    in_valid[d]  = 1'b1;
    in_data[d]   = w;
    in_nbytes[d] = nb;
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      in_valid[d] = 1'b0; out_ready[d] = 1'b0; in_data[d] = '0; in_nbytes[d] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if ({out_valid[d], out_last[d], busy[d], out_data[d]} !== 11'h000) begin
        n_bad++;
        $display("FAIL reset_outputs[%0d]: got v=%b l=%b b=%b d=%h expected all zero",
                 d, out_valid[d], out_last[d], busy[d], out_data[d]);
      end
    end
    @(negedge clk) reset_n = 1'b1;
    #1;
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (in_ready[d] !== 1'b1) begin
        n_bad++;
        $display("FAIL reset_in_ready[%0d]: got %b expected 1", d, in_ready[d]);
      end
    end
  endtask

  task automatic test_msb_basic();
    logic [7:0] exp [4] = '{8'h12, 8'h34, 8'h56, 8'h78};
    out_ready[0] = 1'b1;
    drive_word(0, 32'h12345678, 2'd3);
    cyc();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({out_valid[0], out_last[0], out_data[0]} !== {1'b1, i == 3, exp[i]}) begin
        n_bad++;
        $display("FAIL msb_basic beat %0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                 i, out_valid[0], out_last[0], out_data[0], i == 3, exp[i]);
      end
      cyc();
    end
    n_cmp++;
    if ({out_valid[0], busy[0], in_ready[0]} !== 3'b001) begin
      n_bad++;
      $display("FAIL msb_basic idle: got v=%b b=%b r=%b expected v=0 b=0 r=1",
               out_valid[0], busy[0], in_ready[0]);
    end
  endtask

  task automatic test_lsb_short();
    logic [7:0] exp [2] = '{8'hD4, 8'hC3};
    out_ready[1] = 1'b1;
    drive_word(1, 32'hA1B2C3D4, 2'd1);
    cyc();
    in_valid[1] = 1'b0;
    for (int i = 0; i < 2; i++) begin
      n_cmp++;
      if ({out_valid[1], out_last[1], out_data[1]} !== {1'b1, i == 1, exp[i]}) begin
        n_bad++;
        $display("FAIL lsb_short beat %0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                 i, out_valid[1], out_last[1], out_data[1], i == 1, exp[i]);
      end
      cyc();
    end
    n_cmp++;
    if ({out_valid[1], busy[1]} !== 2'b00) begin
      n_bad++;
      $display("FAIL lsb_short idle: got v=%b b=%b expected 0 0", out_valid[1], busy[1]);
    end
  endtask

  task automatic test_backpressure();
    logic [7:0] exp [7] = '{8'hDE, 8'hAD, 8'hAD, 8'hAD, 8'hAD, 8'hBE, 8'hEF};
    out_ready[0] = 1'b1;
    drive_word(0, 32'hDEADBEEF, 2'd3);
    cyc();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 7; i++) begin
      n_cmp++;
      if ({out_valid[0], out_last[0], out_data[0]} !== {1'b1, i == 6, exp[i]}) begin
        n_bad++;
        $display("FAIL backpressure step %0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                 i, out_valid[0], out_last[0], out_data[0], i == 6, exp[i]);
      end
      out_ready[0] = !(i >= 1 && i <= 3);
      cyc();
    end
    n_cmp++;
    if (out_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL backpressure end: got v=%b expected 0", out_valid[0]);
    end
  endtask

  task automatic test_back_to_back();
    out_ready[0] = 1'b1;
    drive_word(0, 32'h01020304, 2'd3);
    cyc();
    drive_word(0, 32'h05060708, 2'd3);
    for (int i = 0; i < 8; i++) begin
      if (i >= 4) in_valid[0] = 1'b0;
      #0;
      n_cmp++;
      if ({out_valid[0], out_last[0], out_data[0], in_ready[0]} !==
          {1'b1, (i == 3) || (i == 7), 8'(i + 1), (i == 3) || (i == 7)}) begin
        n_bad++;
        $display("FAIL back_to_back beat %0d: got v=%b l=%b d=%h r=%b expected d=%h",
                 i, out_valid[0], out_last[0], out_data[0], in_ready[0], 8'(i + 1));
      end
      cyc();
    end
    n_cmp++;
    if (out_valid[0] !== 1'b0) begin
      n_bad++;
      $display("FAIL back_to_back end: got v=%b expected 0", out_valid[0]);
    end
  endtask

  task automatic test_reset_mid();
    logic [7:0] exp [4] = '{8'hCA, 8'hFE, 8'hF0, 8'h0D};
    out_ready[0] = 1'b1;
    drive_word(0, 32'h12345678, 2'd3);
    cyc();
    in_valid[0] = 1'b0;
    cyc();
    n_cmp++;
    if (out_data[0] !== 8'h34) begin
      n_bad++;
      $display("FAIL reset_mid pre: got d=%h expected 34", out_data[0]);
    end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++;
    if ({out_valid[0], out_last[0], busy[0], out_data[0]} !== 11'h000) begin
      n_bad++;
      $display("FAIL reset_mid async: got v=%b l=%b b=%b d=%h expected all zero",
               out_valid[0], out_last[0], busy[0], out_data[0]);
    end
    @(negedge clk) reset_n = 1'b1;
    @(posedge clk) #1;
    drive_word(0, 32'hCAFEF00D, 2'd3);
    cyc();
    in_valid[0] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({out_valid[0], out_last[0], out_data[0]} !== {1'b1, i == 3, exp[i]}) begin
        n_bad++;
        $display("FAIL reset_mid beat %0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                 i, out_valid[0], out_last[0], out_data[0], i == 3, exp[i]);
      end
      cyc();
    end
  endtask

  task automatic test_fixed_len();
    logic [7:0] exp [4] = '{8'h11, 8'h22, 8'h33, 8'h44};
    out_ready[2] = 1'b1;
    drive_word(2, 32'h11223344, 2'd0);
    cyc();
    in_valid[2] = 1'b0;
    for (int i = 0; i < 4; i++) begin
      n_cmp++;
      if ({out_valid[2], out_last[2], out_data[2]} !== {1'b1, i == 3, exp[i]}) begin
        n_bad++;
        $display("FAIL fixed_len beat %0d: got v=%b l=%b d=%h expected v=1 l=%b d=%h",
                 i, out_valid[2], out_last[2], out_data[2], i == 3, exp[i]);
      end
      cyc();
    end
    n_cmp++;
    if (busy[2] !== 1'b0) begin
      n_bad++;
      $display("FAIL fixed_len idle: got b=%b expected 0", busy[2]);
    end
  endtask

  // Reference: each accepted word contributes an ordered list of bytes; the
  // stream is valid exactly while that list is non-empty.
  task automatic test_random(input int d);
    logic [7:0]  qd [$];
    bit          ql [$];
    bit          msb   = (d != 1);
    bit          fixed = (d == 2);
    bit          exp_rdy;
    int          n;
    logic [31:0] w;
    for (int c = 0; c < 306; c++) begin
      n_cmp++;
      if ({out_valid[d], busy[d]} !== {2{qd.size() != 0}}) begin
        n_bad++;
        $display("FAIL random[%0d] valid c=%0d: got v=%b b=%b expected %b",
                 d, c, out_valid[d], busy[d], qd.size() != 0);
      end
      if (qd.size() != 0) begin
        n_cmp++;
        if ({out_last[d], out_data[d]} !== {ql[0], qd[0]}) begin
          n_bad++;
          $display("FAIL random[%0d] byte c=%0d: got l=%b d=%h expected l=%b d=%h",
                   d, c, out_last[d], out_data[d], ql[0], qd[0]);
        end
      end
      if (c < 300) begin
        out_ready[d] = ($urandom_range(0, 3) != 0);
        in_valid[d]  = ($urandom_range(0, 2) != 0);
      end else begin
        out_ready[d] = 1'b1;
        in_valid[d]  = 1'b0;
      end
      in_data[d]   = $urandom;
      in_nbytes[d] = 2'($urandom);
      exp_rdy = (qd.size() == 0) || (qd.size() == 1 && out_ready[d]);
      #1;
      n_cmp++;
      if (in_ready[d] !== exp_rdy) begin
        n_bad++;
        $display("FAIL random[%0d] in_ready c=%0d: got %b expected %b", d, c, in_ready[d], exp_rdy);
      end
      if (out_ready[d] && qd.size() != 0) begin
        void'(qd.pop_front());
        void'(ql.pop_front());
      end
      if (in_valid[d] && exp_rdy) begin
        w = in_data[d];
        n = fixed ? 4 : int'(in_nbytes[d]) + 1;
        for (int k = 0; k < n; k++) begin
          qd.push_back(msb ? 8'(w >> (24 - 8 * k)) : 8'(w >> (8 * k)));
          ql.push_back(k == n - 1);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_msb_basic();
    test_lsb_short();
    test_backpressure();
    test_back_to_back();
    test_reset_mid();
    test_fixed_len();
    for (int d = 0; d < 3; d++) test_random(d);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
